mult_exhaustive_checker: RTL and testbench

Exhaustive functional evaluator placed directly downstream of each generated candidate `multiplier` in the design-space-exploration flow. It sweeps every operand pair through the candidate's `A`/`B` inputs and captures the candidate's `P` output. Each capture is compared against the exact product `A*B`. The block reports the mismatch count, the total bit-error count, and the first failing vector, which the RL environment uses as the candidate's correctness reward.

---
 rtl/mult_exhaustive_checker.sv | 132 +++++++++++++
 tb/tb_mult_exhaustive_checker.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_exhaustive_checker.sv
// Exhaustive sweep checker for a combinational multiplier candidate.
// Reports mismatch count, bit-error sum and the first failing vector.
module mult_exhaustive_checker #(
  parameter int WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic [WIDTH-1:0]                  A_out,
  output logic [WIDTH-1:0]                  B_out,
  input  logic [2*WIDTH-1:0]                P_in,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [2*WIDTH:0]                  err_count,
  output logic [2*WIDTH+$clog2(2*WIDTH):0]  bit_err_sum,
  output logic                              first_fail_valid,
  output logic [WIDTH-1:0]                  first_fail_a,
  output logic [WIDTH-1:0]                  first_fail_b
);

  localparam int PW    = 2 * WIDTH;
  localparam int N     = 1 << PW;
  localparam int CNT_W = PW + 1;
  localparam int BIT_W = PW + $clog2(PW) + 1;
  localparam int PC_W  = $clog2(PW) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [PW-1:0]    idx;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic [PW-1:0]    s_p;
  logic             s_valid;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    diff;
  logic             mis;
  logic [PC_W-1:0]  pc;

  assign last   = (idx == PW'(N - 1));
  assign accept = start && ((state == IDLE) || (state == DONE));

  // Operands come straight from the index while sweeping, else zero.
  assign A_out = (state == RUN) ? idx[PW-1:WIDTH] : '0;
  assign B_out = (state == RUN) ? idx[WIDTH-1:0]  : '0;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

  // Exact reference product and per-sample error popcount.
  always_comb begin
    prod = PW'(s_a) * PW'(s_b);
    diff = s_p ^ prod;
    mis  = (diff != '0);
    pc   = '0;
    for (int i = 0; i < PW; i++) begin
      pc = pc + PC_W'(diff[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; start is only honoured in IDLE or DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Index, sample stage and result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx              <= '0;
      s_a              <= '0;
      s_b              <= '0;
      s_p              <= '0;
      s_valid          <= 1'b0;
      err_count        <= '0;
      bit_err_sum      <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
    end else if (accept) begin
      idx              <= '0;
      s_valid          <= 1'b0;
      err_count        <= '0;
      bit_err_sum      <= '0;
      first_fail_valid <= 1'b0;
      first_fail_a     <= '0;
      first_fail_b     <= '0;
    end else begin
      if (state == RUN) begin
        s_a     <= A_out;
        s_b     <= B_out;
        s_p     <= P_in;
        s_valid <= 1'b1;
        if (!last) idx <= idx + 1'b1;
      end else begin
        s_valid <= 1'b0;
      end
      if (s_valid) begin
        err_count   <= err_count + CNT_W'(mis);
        bit_err_sum <= bit_err_sum + BIT_W'(pc);
        if (!first_fail_valid && mis) begin
          first_fail_valid <= 1'b1;
          first_fail_a     <= s_a;
          first_fail_b     <= s_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_exhaustive_checker.sv
// Directed bench for mult_exhaustive_checker with WIDTH=2.
// A behavioural candidate multiplier has selectable fault modes.
module tb_mult_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] A_out, B_out;
  logic [3:0] P_in;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [6:0] bit_err_sum;
  logic       first_fail_valid;
  logic [1:0] first_fail_a, first_fail_b;

  int mode;
  int total  = 0;
  int passed = 0;

  int  done_edge;
  int  seq_err;
  logic busy0, done0;
  logic [4:0] err0;
  logic [6:0] bits0;
  logic ffv0;

  always #5 clk = ~clk;

  mult_exhaustive_checker #(.WIDTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .A_out(A_out),
    .B_out(B_out),
    .P_in(P_in),
    .busy(busy),
    .done(done),
    .pass(pass),
    .err_count(err_count),
    .bit_err_sum(bit_err_sum),
    .first_fail_valid(first_fail_valid),
    .first_fail_a(first_fail_a),
    .first_fail_b(first_fail_b)
  );

  // Candidate: 0 exact, 1 stuck at zero, 2 bit0 inverted.
  always_comb begin
    P_in = 4'(A_out) * 4'(B_out);
    if (mode == 1) P_in = 4'd0;
    if (mode == 2) P_in = P_in ^ 4'd1;
  end

  task automatic sweep(input int x1, input int x2, input bit seq);
    done_edge = 0;
    seq_err   = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    busy0 = busy;
    done0 = done;
    err0  = err_count;
    bits0 = bit_err_sum;
    ffv0  = first_fail_valid;
    for (int c = 0; c < 40; c++) begin
      if (seq && c < 16) begin
        if (A_out !== 2'(c >> 2) || B_out !== 2'(c & 3))
          seq_err++;
      end
      if (done) begin
        done_edge = c;
        break;
      end
      start = ((c + 1) == x1) || ((c + 1) == x2);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    mode  = 0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy, done, pass, A_out, B_out, err_count, bit_err_sum,
         first_fail_valid, first_fail_a, first_fail_b} !== '0)
      $display("FAIL reset_outputs got busy=%0b done=%0b err=%0d",
               busy, done, err_count);
    else passed++;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_hold busy=%0b done=%0b want 0 0", busy, done);
    else passed++;
  endtask

  task automatic test_exact();
    mode = 0;
    sweep(0, 0, 1'b1);
    total++;
    if (busy0 !== 1'b1)
      $display("FAIL exact_busy_e0 got %0b want 1", busy0);
    else passed++;
    total++;
    if (done_edge !== 17)
      $display("FAIL exact_done_edge got %0d want 17", done_edge);
    else passed++;
    total++;
    if (seq_err !== 0)
      $display("FAIL scoreboard_seq got %0d bad want 0", seq_err);
    else passed++;
    total++;
    if (pass !== 1'b1 || busy !== 1'b0)
      $display("FAIL exact_pass pass=%0b busy=%0b want 1 0", pass, busy);
    else passed++;
    total++;
    if (err_count !== 5'd0 || bit_err_sum !== 7'd0 ||
        first_fail_valid !== 1'b0)
      $display("FAIL exact_counts err=%0d bits=%0d ffv=%0b want 0 0 0",
               err_count, bit_err_sum, first_fail_valid);
    else passed++;
    total++;
    if (A_out !== 2'd0 || B_out !== 2'd0)
      $display("FAIL done_operands a=%0d b=%0d want 0 0", A_out, B_out);
    else passed++;
  endtask

  task automatic test_stuck_zero();
    mode = 1;
    sweep(0, 0, 1'b0);
    total++;
    if (done_edge !== 17)
      $display("FAIL stuck_done_edge got %0d want 17", done_edge);
    else passed++;
    total++;
    if (err_count !== 5'd9 || bit_err_sum !== 7'd14)
      $display("FAIL stuck_counts err=%0d bits=%0d want 9 14",
               err_count, bit_err_sum);
    else passed++;
    total++;
    if (first_fail_valid !== 1'b1 || first_fail_a !== 2'd1 ||
        first_fail_b !== 2'd1)
      $display("FAIL stuck_first v=%0b a=%0d b=%0d want 1 1 1",
               first_fail_valid, first_fail_a, first_fail_b);
    else passed++;
    total++;
    if (pass !== 1'b0 || done !== 1'b1)
      $display("FAIL stuck_pass pass=%0b done=%0b want 0 1", pass, done);
    else passed++;
  endtask

  task automatic test_bit0_flip();
    mode = 2;
    sweep(0, 0, 1'b0);
    total++;
    if (done0 !== 1'b0 || err0 !== 5'd0 || bits0 !== 7'd0 || ffv0 !== 1'b0)
      $display("FAIL restart_clear done=%0b err=%0d bits=%0d ffv=%0b",
               done0, err0, bits0, ffv0);
    else passed++;
    total++;
    if (err_count !== 5'd16 || bit_err_sum !== 7'd16)
      $display("FAIL flip_counts err=%0d bits=%0d want 16 16",
               err_count, bit_err_sum);
    else passed++;
    total++;
    if (first_fail_valid !== 1'b1 || first_fail_a !== 2'd0 ||
        first_fail_b !== 2'd0)
      $display("FAIL flip_first v=%0b a=%0d b=%0d want 1 0 0",
               first_fail_valid, first_fail_a, first_fail_b);
    else passed++;
  endtask

  task automatic test_back_to_back();
    mode = 1;
    sweep(3, 10, 1'b1);
    total++;
    if (done_edge !== 17 || seq_err !== 0)
      $display("FAIL busy_start edge=%0d seq=%0d want 17 0",
               done_edge, seq_err);
    else passed++;
    total++;
    if (err_count !== 5'd9 || bit_err_sum !== 7'd14)
      $display("FAIL busy_start_counts err=%0d bits=%0d want 9 14",
               err_count, bit_err_sum);
    else passed++;
    sweep(0, 0, 1'b0);
    total++;
    if (done0 !== 1'b0 || err0 !== 5'd0 || busy0 !== 1'b1)
      $display("FAIL restart_edge done=%0b err=%0d busy=%0b want 0 0 1",
               done0, err0, busy0);
    else passed++;
    total++;
    if (done_edge !== 17 || err_count !== 5'd9 || bit_err_sum !== 7'd14 ||
        first_fail_a !== 2'd1 || first_fail_b !== 2'd1)
      $display("FAIL restart_result edge=%0d err=%0d bits=%0d want 17 9 14",
               done_edge, err_count, bit_err_sum);
    else passed++;
  endtask

  task automatic test_mid_reset();
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({busy, done, pass, A_out, B_out, err_count, bit_err_sum,
         first_fail_valid, first_fail_a, first_fail_b} !== '0)
      $display("FAIL midreset_outputs busy=%0b a=%0d b=%0d err=%0d",
               busy, A_out, B_out, err_count);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || err_count !== 5'd0)
      $display("FAIL midreset_idle busy=%0b done=%0b err=%0d want 0 0 0",
               busy, done, err_count);
    else passed++;
    mode = 0;
    sweep(0, 0, 1'b1);
    total++;
    if (done_edge !== 17 || pass !== 1'b1 || seq_err !== 0)
      $display("FAIL post_reset_sweep edge=%0d pass=%0b seq=%0d",
               done_edge, pass, seq_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_exact();
    test_stuck_zero();
    test_bit0_flip();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
